// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader.
// Optional checksum feature: LOADER_CHECKSUM_EN (see program_loader.sv).
package loader_pkg;

  // Loader sequencing states; CHECK and ERROR are only reachable with the
  // checksum feature built in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    BYTES  = 3'd3,
    WRITE  = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;
  localparam int LEN_W          = 16;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, RAM write port and core-control outputs of the loader.
//
// Handshake: a byte transfers on a rising clock edge where i_byte_valid and
// o_byte_ready are both 1. The source holds i_byte stable while i_byte_valid
// is 1 and the byte has not yet transferred; ready never depends on valid.
// o_ram_set is a one-cycle write strobe with o_ram_addr/o_ram_data stable in
// that same cycle; the RAM write port has no back-pressure.
interface program_loader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              i_start;
  logic              i_byte_valid;
  logic [7:0]        i_byte;
  logic              o_byte_ready;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [DATA_W-1:0] o_ram_data;
  logic              o_ram_set;
  logic              o_cpu_reset;
  logic              o_done;
  logic              o_error;

  // Byte source / system side.
  modport master (
    output i_start, i_byte_valid, i_byte,
    input  o_byte_ready, o_ram_addr, o_ram_data, o_ram_set,
           o_cpu_reset, o_done, o_error
  );

  // Loader side.
  modport slave (
    input  i_start, i_byte_valid, i_byte,
    output o_byte_ready, o_ram_addr, o_ram_data, o_ram_set,
           o_cpu_reset, o_done, o_error
  );
endinterface

// File: rtl/program_loader_byte_assembler.sv
// Packs four accepted bytes, first byte into the MSB, into one 32-bit word.
// The completed word is presented combinationally alongside the 4th byte so
// the loader can register it on the same edge the byte is accepted.
module byte_assembler
  import loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [7:0]        i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_valid
);

  logic [1:0]        cnt_q;
  logic [WORD_W-1:0] shift_q;

  // Earlier bytes move up one lane, the new byte enters at [7:0].
  assign o_word       = {shift_q[WORD_W-9:0], i_byte};
  assign o_word_valid = i_valid && (cnt_q == 2'd3);

  // Byte counter and shift register; the counter wraps to 0 after each word.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q   <= 2'd0;
      shift_q <= '0;
    end else if (i_clear) begin
      cnt_q   <= 2'd0;
      shift_q <= '0;
    end else if (i_valid) begin
      cnt_q   <= cnt_q + 2'd1;
      shift_q <= o_word;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a length-prefixed byte image, writes 32-bit words
// into program RAM from address 0 and holds the core in reset until done.
// Build option: define LOADER_CHECKSUM_EN to require a trailing XOR checksum
// byte over the payload; a mismatch parks the loader in ERROR.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  program_loader_if.slave bus,
  output loader_state_t o_dbg_state
);

  loader_state_t     state_q;
  logic              byte_ready_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_data_q;
  logic              ram_set_q;
  logic              cpu_reset_q;
  logic              done_q;
  logic [7:0]        len_lo_q;
  logic [LEN_W-1:0]  rem_q;      // words still to be written, including current
`ifdef LOADER_CHECKSUM_EN
  logic              error_q;
  logic [7:0]        csum_q;     // running XOR of payload bytes
`endif

  logic              fire;
  logic              restart;
  logic              asm_valid;
  logic [WORD_W-1:0] asm_word;
  logic              asm_word_valid;
  logic [LEN_W-1:0]  len_word;

  assign fire      = bus.i_byte_valid && byte_ready_q;
  assign restart   = bus.i_start &&
                     (state_q == IDLE || state_q == DONE || state_q == ERROR);
  assign asm_valid = fire && (state_q == BYTES);
  assign len_word  = {bus.i_byte, len_lo_q};

  byte_assembler u_asm (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_clear      (restart),
    .i_valid      (asm_valid),
    .i_byte       (bus.i_byte),
    .o_word       (asm_word),
    .o_word_valid (asm_word_valid)
  );

  // Loader sequencing with all outputs registered alongside the state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      byte_ready_q <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_set_q    <= 1'b0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      len_lo_q     <= '0;
      rem_q        <= '0;
`ifdef LOADER_CHECKSUM_EN
      error_q      <= 1'b0;
      csum_q       <= '0;
`endif
    end else begin
      ram_set_q <= 1'b0;
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (bus.i_start) begin
            state_q      <= LEN_LO;
            byte_ready_q <= 1'b1;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            ram_addr_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
            error_q      <= 1'b0;
            csum_q       <= '0;
`endif
          end
        end

        LEN_LO: begin
          if (fire) begin
            len_lo_q <= bus.i_byte;
            state_q  <= LEN_HI;
          end
        end

        LEN_HI: begin
          if (fire) begin
            rem_q <= len_word;
            if (len_word == '0) begin
`ifdef LOADER_CHECKSUM_EN
              // An empty image still carries a checksum byte (0x00).
              state_q      <= CHECK;
`else
              state_q      <= DONE;
              byte_ready_q <= 1'b0;
              cpu_reset_q  <= 1'b0;
              done_q       <= 1'b1;
`endif
            end else begin
              state_q <= BYTES;
            end
          end
        end

        BYTES: begin
          if (fire) begin
`ifdef LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ bus.i_byte;
`endif
            if (asm_word_valid) begin
              ram_data_q   <= asm_word;
              ram_set_q    <= 1'b1;
              byte_ready_q <= 1'b0;
              state_q      <= WRITE;
            end
          end
        end

        WRITE: begin
          // Address advances after the strobe; wraps naturally at 2^ADDR_W.
          ram_addr_q <= ram_addr_q + ADDR_W'(1);
          rem_q      <= rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
            state_q      <= CHECK;
            byte_ready_q <= 1'b1;
`else
            state_q      <= DONE;
            cpu_reset_q  <= 1'b0;
            done_q       <= 1'b1;
`endif
          end else begin
            state_q      <= BYTES;
            byte_ready_q <= 1'b1;
          end
        end

        CHECK: begin
`ifdef LOADER_CHECKSUM_EN
          if (fire) begin
            byte_ready_q <= 1'b0;
            if (bus.i_byte == csum_q) begin
              state_q     <= DONE;
              cpu_reset_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              state_q <= ERROR;
              error_q <= 1'b1;
            end
          end
`else
          state_q      <= IDLE;
          byte_ready_q <= 1'b0;
`endif
        end

        default: begin
          state_q      <= IDLE;
          byte_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_byte_ready = byte_ready_q;
  assign bus.o_ram_addr   = ram_addr_q;
  assign bus.o_ram_data   = ram_data_q;
  assign bus.o_ram_set    = ram_set_q;
  assign bus.o_cpu_reset  = cpu_reset_q;
  assign bus.o_done       = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign bus.o_error      = error_q;
`else
  assign bus.o_error      = 1'b0;
`endif
  assign o_dbg_state      = state_q;

endmodule
